// File: rtl/npc_rf_pkg.sv
// Shared definitions for the NPC integer register file.
// Holds the default geometry, the in-flight counter type and a helper
// that turns a port index into the low bit of its slice on a flattened bus.
package npc_rf_pkg;

    localparam int DEF_XLEN = 64;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);
    localparam int DEF_CNTW = 2;
    localparam int DEF_NRD  = 2;
    localparam int DEF_NWB  = 2;

    typedef logic [DEF_CNTW-1:0] sb_cnt_t;

    // Low bit of slice k on a bus made of equal-width fields of width w.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// In-flight writer counter for one architectural register.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   flush             - clear the counter next cycle (wins over inc/dec)
//   inc               - one accepted issue targeting this register
//   dec               - number of write-back ports completing this register
//   cnt               - current pending-writer count
//   saturated         - cnt is at its maximum, further issues must stall
//   underflow         - this cycle's completions exceed pending + new writers
module sb_counter #(
    parameter int CNTW = 2,
    parameter int DW   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            inc,
    input  logic [DW-1:0]   dec,
    output logic [CNTW-1:0] cnt,
    output logic            saturated,
    output logic            underflow
);

    // Wide enough that cnt + inc never wraps and dec always fits.
    localparam int SW = CNTW + DW + 1;

    logic [CNTW-1:0] cnt_reg;
    logic [CNTW-1:0] cnt_next;
    logic [SW-1:0]   sum;

    always_comb begin
        sum       = SW'(cnt_reg) + SW'(inc);
        underflow = (sum < SW'(dec));
        cnt_next  = cnt_reg;
        if (flush) begin
            cnt_next = '0;
        end else if (underflow) begin
            // Spurious completion: clamp at zero, the top latches the error.
            cnt_next = '0;
        end else begin
            cnt_next = CNTW'(sum - SW'(dec));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt       = cnt_reg;
    assign saturated = (cnt_reg == {CNTW{1'b1}});

endmodule

// File: rtl/gpr_scoreboard_file.sv
// Integer register file with write-back forwarding and a RAW scoreboard.
// Ports (flattened buses, port k at slice k):
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   rd_addr/data   - NRD combinational read ports, forwarded from write-back
//   rd_busy        - operand still has a pending writer after this cycle's wb
//   wb_valid/addr/data - NWB write-back ports, highest port wins on conflict
//   iss_valid/rd   - issue of an instruction writing iss_rd
//   iss_ready      - issue accepted (destination counter not saturated)
//   flush          - clear all pending counters
//   dbg_addr/data  - forwarded debug read port
//   sb_err         - sticky: write-back found no pending writer
module gpr_scoreboard_file
    import npc_rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD,
    parameter int NWB  = DEF_NWB,
    parameter int CNTW = DEF_CNTW,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWB-1:0]      wb_valid,
    input  logic [NWB*AW-1:0]   wb_addr,
    input  logic [NWB*XLEN-1:0] wb_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic                sb_err
);

    localparam int DW = $clog2(NWB + 1);
    localparam int BW = CNTW + DW;

    logic [XLEN-1:0] fwd_data [NREG];
    logic [CNTW-1:0] cnt_arr  [NREG];
    logic [DW-1:0]   dec_arr  [NREG];
    logic [NREG-1:0] sat_vec;
    logic [NREG-1:0] udf_vec;
    logic            sb_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 is hardwired: no storage, never pending, never errors.
                assign fwd_data[gi] = '0;
                assign cnt_arr[gi]  = '0;
                assign dec_arr[gi]  = '0;
                assign sat_vec[gi]  = 1'b0;
                assign udf_vec[gi]  = 1'b0;
            end else begin : g_gpr
                logic [XLEN-1:0] data_reg;
                logic [XLEN-1:0] wdata;
                logic            hit;
                logic [DW-1:0]   dec;
                logic            inc;
                logic [CNTW-1:0] cnt;
                logic            sat;
                logic            udf;

                // Ascending scan so the highest matching port wins.
                always_comb begin
                    hit   = 1'b0;
                    dec   = '0;
                    wdata = '0;
                    for (int k = 0; k < NWB; k++) begin
                        if (wb_valid[k] &&
                            wb_addr[slice_lo(k, AW) +: AW] == AW'(gi)) begin
                            hit   = 1'b1;
                            dec   = dec + DW'(1);
                            wdata = wb_data[slice_lo(k, XLEN) +: XLEN];
                        end
                    end
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        data_reg <= '0;
                    end else if (hit) begin
                        data_reg <= wdata;
                    end
                end

                assign inc = iss_valid & iss_ready & (iss_rd == AW'(gi));

                sb_counter #(
                    .CNTW (CNTW),
                    .DW   (DW)
                ) u_cnt (
                    .clock     (clock),
                    .reset     (reset),
                    .flush     (flush),
                    .inc       (inc),
                    .dec       (dec),
                    .cnt       (cnt),
                    .saturated (sat),
                    .underflow (udf)
                );

                assign fwd_data[gi] = hit ? wdata : data_reg;
                assign cnt_arr[gi]  = cnt;
                assign dec_arr[gi]  = dec;
                assign sat_vec[gi]  = sat;
                assign udf_vec[gi]  = udf;
            end
        end
    endgenerate

    // Read ports: a writer completing this cycle is forwarded, so the operand
    // is busy only if more writers remain than are completing now.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[slice_lo(i, XLEN) +: XLEN] = fwd_data[rd_addr[slice_lo(i, AW) +: AW]];
            rd_busy[i] = BW'(cnt_arr[rd_addr[slice_lo(i, AW) +: AW]]) >
                         BW'(dec_arr[rd_addr[slice_lo(i, AW) +: AW]]);
        end
    end

    // Based on the registered count only: a same-cycle completion does not
    // free a slot for an issue in the same cycle.
    assign iss_ready = (iss_rd == '0) | ~sat_vec[iss_rd];
    assign dbg_data  = fwd_data[dbg_addr];

    // Counters are cleared by a flush, so completions in that cycle may
    // legitimately find nothing pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_err_reg <= 1'b0;
        end else if (!flush && |udf_vec) begin
            sb_err_reg <= 1'b1;
        end
    end

    assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
module tb_gpr_scoreboard_file;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWB  = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWB-1:0]      wb_valid;
    logic [NWB*AW-1:0]   wb_addr;
    logic [NWB*XLEN-1:0] wb_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic                sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    gpr_scoreboard_file dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .sb_err    (sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle();
        reset     = 1'b0;
        wb_valid  = '0;
        wb_addr   = '0;
        wb_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wb(input int p, input int a, input logic [63:0] d);
        wb_valid[p]             = 1'b1;
        wb_addr[p*AW +: AW]     = AW'(a);
        wb_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input int a);
        iss_valid = 1'b1;
        iss_rd    = AW'(a);
    endtask

    function automatic logic [63:0] rdd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    // Inputs change 1 time unit after the rising edge; #1 more lets the
    // combinational outputs settle before checking.
    task automatic settle();
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        rd_addr  = '0;
        dbg_addr = '0;
        idle();
        reset = 1'b1;
        step();

        // Reset state
        set_rd(0, 5); set_rd(1, 5); iss_rd = 5'd5; dbg_addr = 5'd5;
        settle();
        chk("rst_rd0", rdd(0), 64'h0);
        chk("rst_rd1", rdd(1), 64'h0);
        chk("rst_busy", 64'(rd_busy), 64'h0);
        chk("rst_ready", 64'(iss_ready), 64'h1);
        chk("rst_dbg", dbg_data, 64'h0);
        chk("rst_err", 64'(sb_err), 64'h0);

        // Write to x0 is ignored
        set_rd(0, 0); set_wb(0, 0, 64'hDEAD);
        settle();
        chk("x0_fwd", rdd(0), 64'h0);
        step();
        set_rd(0, 0);
        settle();
        chk("x0_read", rdd(0), 64'h0);
        chk("x0_err", 64'(sb_err), 64'h0);

        // Issue x5: busy only from next cycle
        set_rd(0, 5); issue(5);
        settle();
        chk("x5_iss_ready", 64'(iss_ready), 64'h1);
        chk("x5_busy_same", 64'(rd_busy[0]), 64'h0);
        step();
        settle();
        chk("x5_busy", 64'(rd_busy[0]), 64'h1);
        set_wb(0, 5, 64'h1234); set_rd(1, 5);
        settle();
        chk("x5_fwd_busy", 64'(rd_busy), 64'h0);
        chk("x5_fwd_rd0", rdd(0), 64'h1234);
        chk("x5_fwd_rd1", rdd(1), 64'h1234);
        step();
        settle();
        chk("x5_reg", rdd(0), 64'h1234);
        chk("x5_busy_after", 64'(rd_busy[0]), 64'h0);

        // Saturate x7, then issue+wb at max: issue rejected, count drops
        set_rd(0, 7); dbg_addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            issue(7);
            settle();
            chk($sformatf("x7_iss%0d_ready", i), 64'(iss_ready), 64'h1);
            step();
        end
        issue(7); set_wb(0, 7, 64'h71);
        settle();
        chk("x7_sat_ready", 64'(iss_ready), 64'h0);
        chk("x7_wb1_busy", 64'(rd_busy[0]), 64'h1);
        chk("x7_wb1_dbg", dbg_data, 64'h71);
        step();
        set_wb(1, 7, 64'h72);
        settle();
        chk("x7_wb2_ready", 64'(iss_ready), 64'h1);
        chk("x7_wb2_busy", 64'(rd_busy[0]), 64'h1);
        chk("x7_wb2_dbg", dbg_data, 64'h72);
        step();
        set_wb(0, 7, 64'h73);
        settle();
        chk("x7_wb3_busy", 64'(rd_busy[0]), 64'h0);
        chk("x7_wb3_dbg", dbg_data, 64'h73);
        step();
        settle();
        chk("x7_final_busy", 64'(rd_busy[0]), 64'h0);
        chk("x7_final_rd", rdd(0), 64'h73);
        chk("x7_err", 64'(sb_err), 64'h0);

        // Dual write-back to x9 with two pending: highest port wins
        issue(9); step();
        issue(9); step();
        set_rd(1, 9);
        settle();
        chk("x9_busy_pend", 64'(rd_busy[1]), 64'h1);
        set_wb(0, 9, 64'hA); set_wb(1, 9, 64'hB);
        settle();
        chk("x9_fwd", rdd(1), 64'hB);
        chk("x9_fwd_busy", 64'(rd_busy[1]), 64'h0);
        step();
        settle();
        chk("x9_reg", rdd(1), 64'hB);
        chk("x9_busy", 64'(rd_busy[1]), 64'h0);
        chk("x9_err", 64'(sb_err), 64'h0);

        // Flush with two pending on x4 plus issue x4; wb x11 during flush
        issue(4); step();
        issue(4); step();
        set_rd(0, 4); set_rd(1, 11);
        settle();
        chk("x4_busy_pend", 64'(rd_busy[0]), 64'h1);
        flush = 1'b1; issue(4); set_wb(0, 11, 64'h11);
        step();
        settle();
        chk("x4_flush_busy", 64'(rd_busy[0]), 64'h0);
        chk("x11_flush_wr", rdd(1), 64'h11);
        chk("flush_no_err", 64'(sb_err), 64'h0);

        // Stray write-back to x3 sets the sticky error
        set_wb(0, 3, 64'h3);
        step();
        settle();
        chk("x3_err_set", 64'(sb_err), 64'h1);
        step();
        settle();
        chk("x3_err_sticky", 64'(sb_err), 64'h1);

        // Reset mid-stream
        issue(6); step();
        issue(6); step();
        set_rd(0, 6);
        settle();
        chk("x6_busy_pend", 64'(rd_busy[0]), 64'h1);
        reset = 1'b1; issue(6); set_wb(0, 6, 64'h66);
        step();
        set_rd(0, 6); set_rd(1, 9); dbg_addr = 5'd7; iss_rd = 5'd6;
        settle();
        chk("mrst_x6_rd", rdd(0), 64'h0);
        chk("mrst_x9_rd", rdd(1), 64'h0);
        chk("mrst_busy", 64'(rd_busy), 64'h0);
        chk("mrst_dbg", dbg_data, 64'h0);
        chk("mrst_ready", 64'(iss_ready), 64'h1);
        chk("mrst_err", 64'(sb_err), 64'h0);
        set_rd(0, 5);
        settle();
        chk("mrst_x5_rd", rdd(0), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
